// File: rtl/contrast_stats_if.sv
// Pixel-in / statistics-out bundle for contrast_stats.
// master = pixel source and result consumer, slave = the statistics block.
interface contrast_stats_if;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eof;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;
  logic        stat_valid;
  logic        stat_ready;
  logic [7:0]  stat_lo;
  logic [7:0]  stat_hi;
  logic [15:0] stat_gain;

  modport master (
    output pix_valid, pix_sof, pix_eof, r_in, g_in, b_in, stat_ready,
    input  pix_ready, stat_valid, stat_lo, stat_hi, stat_gain
  );

  modport slave (
    input  pix_valid, pix_sof, pix_eof, r_in, g_in, b_in, stat_ready,
    output pix_ready, stat_valid, stat_lo, stat_hi, stat_gain
  );
endinterface

// File: rtl/contrast_stats.sv
// Per-frame min/max of an RGB stream plus stretch gain floor((255<<FRAC_BITS)/(max-min)), clamped.
// Result 8+FRAC_BITS cycles after eof; pixels stalled (pix_ready=0) from eof until result handshake.
module contrast_stats #(
  parameter int          FRAC_BITS = 8,
  parameter logic [15:0] GAIN_MAX  = 16'h0400
) (
  input  logic             clk,
  input  logic             rst_n,
  contrast_stats_if.slave  bus
);

  localparam int          ITERS    = 8 + FRAC_BITS;
  localparam int          CW       = $clog2(ITERS);
  localparam logic [CW-1:0] LAST   = CW'(ITERS - 1);
  localparam logic [15:0] DIVIDEND = 16'(255 << FRAC_BITS);
  // Dividend is left-aligned so the next bit to shift in is always bit 15.
  localparam logic [15:0] DVD_INIT = DIVIDEND << (16 - ITERS);
  localparam logic [15:0] UNITY    = 16'(1 << FRAC_BITS);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_HOLD} state_t;

  state_t        r_state;
  logic          r_pix_ready;
  logic          r_stat_valid;
  logic [7:0]    r_min;
  logic [7:0]    r_max;
  logic [7:0]    r_lo;
  logic [7:0]    r_hi;
  logic [15:0]   r_gain;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_dvd;
  logic [7:0]    r_rem;
  logic [14:0]   r_quo;

  logic          w_fire;
  logic [7:0]    w_rg_min;
  logic [7:0]    w_rg_max;
  logic [7:0]    w_pmin;
  logic [7:0]    w_pmax;
  logic [7:0]    w_acc_min;
  logic [7:0]    w_acc_max;
  logic [7:0]    w_d;
  logic          w_d_zero;
  logic [8:0]    w_rem_sh;
  logic [8:0]    w_diff;
  logic          w_ge;
  logic [7:0]    w_rem_nx;
  logic [15:0]   w_quo_nx;
  logic [15:0]   w_gain;

  assign w_fire    = bus.pix_valid & r_pix_ready;
  assign w_rg_min  = (bus.r_in < bus.g_in) ? bus.r_in : bus.g_in;
  assign w_rg_max  = (bus.r_in > bus.g_in) ? bus.r_in : bus.g_in;
  assign w_pmin    = (bus.b_in < w_rg_min) ? bus.b_in : w_rg_min;
  assign w_pmax    = (bus.b_in > w_rg_max) ? bus.b_in : w_rg_max;
  assign w_acc_min = (w_pmin < r_min) ? w_pmin : r_min;
  assign w_acc_max = (w_pmax > r_max) ? w_pmax : r_max;

  assign w_d      = r_max - r_min;
  assign w_d_zero = (w_d == 8'd0);

  // Remainder stays below d, so the shifted value is below 2d and a 9-bit
  // difference's sign bit is an exact "shifted >= d" test.
  assign w_rem_sh = {r_rem, r_dvd[15]};
  assign w_diff   = w_rem_sh - {1'b0, w_d};
  assign w_ge     = ~w_diff[8];
  assign w_rem_nx = w_ge ? w_diff[7:0] : w_rem_sh[7:0];
  assign w_quo_nx = {r_quo, w_ge};
  assign w_gain   = w_d_zero ? UNITY : ((w_quo_nx > GAIN_MAX) ? GAIN_MAX : w_quo_nx);

  assign bus.pix_ready  = r_pix_ready;
  assign bus.stat_valid = r_stat_valid;
  assign bus.stat_lo    = r_lo;
  assign bus.stat_hi    = r_hi;
  assign bus.stat_gain  = r_gain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pix_ready  <= 1'b1;
      r_stat_valid <= 1'b0;
      r_min        <= 8'd0;
      r_max        <= 8'd0;
      r_lo         <= 8'd0;
      r_hi         <= 8'd0;
      r_gain       <= 16'd0;
      r_cnt        <= '0;
      r_dvd        <= 16'd0;
      r_rem        <= 8'd0;
      r_quo        <= 15'd0;
    end else begin
      case (r_state)
        S_IDLE, S_ACCUM: begin
          if (w_fire) begin
            if (bus.pix_sof) begin
              r_min <= w_pmin;
              r_max <= w_pmax;
            end else if (r_state == S_ACCUM) begin
              r_min <= w_acc_min;
              r_max <= w_acc_max;
            end
            // Beats outside a frame (IDLE without sof) are swallowed.
            if (bus.pix_sof || (r_state == S_ACCUM)) begin
              if (bus.pix_eof) begin
                r_state     <= S_DIVIDE;
                r_pix_ready <= 1'b0;
                r_cnt       <= '0;
                r_dvd       <= DVD_INIT;
                r_rem       <= 8'd0;
                r_quo       <= 15'd0;
              end else begin
                r_state <= S_ACCUM;
              end
            end
          end
        end

        S_DIVIDE: begin
          r_cnt <= r_cnt + 1'b1;
          r_dvd <= {r_dvd[14:0], 1'b0};
          if (!w_d_zero) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx[14:0];
          end
          if (r_cnt == LAST) begin
            r_state      <= S_HOLD;
            r_stat_valid <= 1'b1;
            r_lo         <= r_min;
            r_hi         <= r_max;
            r_gain       <= w_gain;
          end
        end

        S_HOLD: begin
          if (bus.stat_ready) begin
            r_state      <= S_IDLE;
            r_stat_valid <= 1'b0;
            r_pix_ready  <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_contrast_stats.sv
// Randomised and directed stimulus for contrast_stats; expected results come from a frame-level model.
module tb_contrast_stats;

  localparam int FRAC = 8;
  localparam int GMAX = 1024;
  localparam int LAT  = 8 + FRAC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  contrast_stats_if bus ();

  contrast_stats #(.FRAC_BITS(FRAC), .GAIN_MAX(16'h0400)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int lo;
    int hi;
    int gain;
    int eof_cyc;
  } exp_t;

  exp_t sb[$];
  int   cur[$];
  bit   in_frame = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;   // 0 random, 1 held low, 2 held high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_gain(input int lo, input int hi);
    int q;
    if (hi == lo) return (1 << FRAC);
    q = (255 << FRAC) / (hi - lo);
    return (q > GMAX) ? GMAX : q;
  endfunction

  // Frame-level model: collect every channel value of the frame, reduce at eof.
  task automatic model_beat(input bit sof, input bit eof, input int r, input int g,
                            input int b, input int e_cyc);
    int lo, hi;
    exp_t e;
    if (sof) begin
      cur.delete();
      in_frame = 1'b1;
    end
    if (in_frame) begin
      cur.push_back(r);
      cur.push_back(g);
      cur.push_back(b);
      if (eof) begin
        lo = 255;
        hi = 0;
        foreach (cur[i]) begin
          if (cur[i] < lo) lo = cur[i];
          if (cur[i] > hi) hi = cur[i];
        end
        e.lo = lo; e.hi = hi; e.gain = ref_gain(lo, hi); e.eof_cyc = e_cyc;
        sb.push_back(e);
        in_frame = 1'b0;
      end
    end
  endtask

  task automatic send_beat(input bit sof, input bit eof, input int r, input int g, input int b);
    bit rdy;
    int n, e_cyc;
    rdy = 1'b0; n = 0; e_cyc = 0;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_eof   = eof;
    bus.r_in      = 8'(r);
    bus.g_in      = 8'(g);
    bus.b_in      = 8'(b);
    while (!rdy && n < 500) begin
      @(negedge clk);
      rdy   = bus.pix_ready;
      e_cyc = cyc + 1;
      @(posedge clk);
      n++;
    end
    #1;
    bus.pix_valid = 1'b0;
    chk("beat_accepted", int'(rdy), 1);
    if (rdy) model_beat(sof, eof, r, g, b, e_cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.stat_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", int'(n < 3000), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frame();
    int len, base, spread, v[3];
    if ($urandom_range(0, 3) == 0)
      send_beat(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 0, 255);
    len    = $urandom_range(1, 16);
    base   = $urandom_range(0, 255);
    spread = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
    for (int i = 0; i < len; i++) begin
      for (int c = 0; c < 3; c++) begin
        v[c] = base + $urandom_range(0, spread);
        if (v[c] > 255) v[c] = 255;
      end
      send_beat(i == 0, i == len - 1, v[0], v[1], v[2]);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // Consumer back-pressure.
  initial begin
    bus.stat_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.stat_ready = ($urandom_range(0, 3) != 0);
        1:       bus.stat_ready = 1'b0;
        default: bus.stat_ready = 1'b1;
      endcase
    end
  end

  // Monitor: latency on each rising stat_valid, contents on each handshake.
  initial begin
    bit   prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (bus.stat_valid && !prev) begin
          chk("result_expected", int'(sb.size() != 0), 1);
          if (sb.size() != 0) chk("latency", cyc - sb[0].eof_cyc, LAT);
        end
        if (bus.stat_valid && bus.stat_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("stat_lo", int'(bus.stat_lo), e.lo);
          chk("stat_hi", int'(bus.stat_hi), e.hi);
          chk("stat_gain", int'(bus.stat_gain), e.gain);
        end
        prev = bus.stat_valid;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int n;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_eof   = 1'b0;
    bus.r_in      = 8'd0;
    bus.g_in      = 8'd0;
    bus.b_in      = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pix_ready", int'(bus.pix_ready), 1);
    chk("rst_stat_valid", int'(bus.stat_valid), 0);
    chk("rst_stat_lo", int'(bus.stat_lo), 0);
    chk("rst_stat_hi", int'(bus.stat_hi), 0);
    chk("rst_stat_gain", int'(bus.stat_gain), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Ramp: min 64 in r, max 191 in b.
    for (int i = 0; i < 126; i++)
      send_beat(i == 0, i == 125, 64 + i, 65 + i, 66 + i);

    // Full-scale range.
    send_beat(1'b1, 1'b0, 30, 0, 200);
    send_beat(1'b0, 1'b0, 17, 255, 90);
    send_beat(1'b0, 1'b1, 128, 128, 128);

    // Flat frame, then single-beat frame.
    for (int i = 0; i < 10; i++) send_beat(i == 0, i == 9, 100, 100, 100);
    send_beat(1'b1, 1'b1, 100, 100, 100);

    // Clamped gain with long consumer stall.
    wait_drain();
    rdy_mode = 1;
    send_beat(1'b1, 1'b0, 100, 101, 100);
    send_beat(1'b0, 1'b1, 101, 100, 100);
    n = 0;
    while (!bus.stat_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("hold_valid_seen", int'(bus.stat_valid), 1);
    repeat (20) begin
      @(negedge clk);
      chk("hold_valid", int'(bus.stat_valid), 1);
      chk("hold_pix_ready", int'(bus.pix_ready), 0);
      chk("hold_lo", int'(bus.stat_lo), 100);
      chk("hold_hi", int'(bus.stat_hi), 101);
      chk("hold_gain", int'(bus.stat_gain), 16'h0400);
    end
    rdy_mode = 2;
    n = 0;
    while (!(bus.stat_valid && bus.stat_ready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_handshake_seen", int'(n < 10), 1);
    @(negedge clk);
    chk("post_hs_pix_ready", int'(bus.pix_ready), 1);
    chk("post_hs_stat_valid", int'(bus.stat_valid), 0);
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Mid-frame sof discards the partial frame.
    send_beat(1'b1, 1'b0, 0, 0, 0);
    send_beat(1'b0, 1'b0, 255, 255, 255);
    send_beat(1'b1, 1'b0, 50, 50, 50);
    send_beat(1'b0, 1'b1, 60, 60, 60);

    // Reset on the fifth divide iteration.
    send_beat(1'b1, 1'b0, 10, 20, 30);
    send_beat(1'b0, 1'b1, 40, 50, 60);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    in_frame = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_div_stat_valid", int'(bus.stat_valid), 0);
    chk("rst_mid_div_pix_ready", int'(bus.pix_ready), 1);
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b0, 90, 20, 130);
    send_beat(1'b0, 1'b0, 70, 70, 70);
    send_beat(1'b0, 1'b1, 25, 140, 33);

    for (int f = 0; f < 40; f++) begin
      rand_frame();
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
    end

    wait_drain();
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
